// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared definitions for the IJTAG/functional data mux: lane state
// encoding and the settle-counter width helper.
package firebird7_in_gate1_tessent_data_mux_pkg;

    // Per-lane source-selection state.
    typedef enum logic [1:0] {
        ST_FUNC  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_IJTAG = 2'd2
    } lane_state_t;

    // Settle counter width: enough bits to hold SETTLE_CYCLES-1, never zero bits.
    function automatic int cnt_width(input int settle_cycles);
        if (settle_cycles < 1) begin
            return 1;
        end
        return (settle_cycles + 1 > 1) ? $clog2(settle_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_lane.sv
// One mux lane: FUNC/HOLD/IJTAG state machine, settle counter and the
// registered WIDTH-bit output. In HOLD the output freezes; the destination
// is decided by select on the cycle the counter reaches zero, so a request
// that reverts mid-settle returns the lane to where it came from.
module firebird7_in_gate1_tessent_data_mux_lane
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             select,
    input  logic [WIDTH-1:0] functional_data,
    input  logic [WIDTH-1:0] ijtag_data,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       state_dbg
);

    localparam int CW = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    lane_state_t      state_q;
    lane_state_t      state_next;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_next;

    // Next-state, counter and output-data selection.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        data_next  = data_q;
        unique case (state_q)
            ST_FUNC: begin
                data_next = functional_data;
                if (select) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_next = ST_IJTAG;
                    end else begin
                        state_next = ST_HOLD;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_IJTAG: begin
                data_next = ijtag_data;
                if (!select) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_next = ST_FUNC;
                    end else begin
                        state_next = ST_HOLD;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_next = select ? ST_IJTAG : ST_FUNC;
                end else begin
                    cnt_next = cnt_q - CW'(1);
                end
            end
            default: begin
                state_next = ST_FUNC;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset wins over any select change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FUNC;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            data_q  <= data_next;
        end
    end

    assign data      = data_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// Top level: unpacks the lane buses, instantiates one lane per channel,
// decodes per-lane state and ORs the HOLD flags into switch_busy.
module firebird7_in_gate1_tessent_data_mux_sync
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int CHANNELS      = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      ijtag_tck,
    input  logic                      ijtag_reset,
    input  logic [CHANNELS-1:0]       ijtag_select,
    input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
    input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       ijtag_active,
    output logic                      switch_busy
);

    logic [1:0]          lane_state [CHANNELS];
    logic [CHANNELS-1:0] lane_hold;

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_lane
            firebird7_in_gate1_tessent_data_mux_lane #(
                .WIDTH         (WIDTH),
                .SETTLE_CYCLES (SETTLE_CYCLES)
            ) u_lane (
                .clk             (ijtag_tck),
                .reset           (ijtag_reset),
                .select          (ijtag_select[k]),
                .functional_data (functional_data_in[k*WIDTH +: WIDTH]),
                .ijtag_data      (ijtag_data_in[k*WIDTH +: WIDTH]),
                .data            (data_out[k*WIDTH +: WIDTH]),
                .state_dbg       (lane_state[k])
            );

            assign ijtag_active[k] = (lane_state[k] == ST_IJTAG);
            assign lane_hold[k]    = (lane_state[k] == ST_HOLD);
        end
    endgenerate

    assign switch_busy = |lane_hold;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv
// Bench for the data mux: a settle-2 instance driven by a vector table
// plus hand sequences, and a settle-0 instance for the direct-switch case.
module tb_firebird7_in_gate1_tessent_data_mux_sync;

    localparam int W  = 3;
    localparam int CH = 2;

    localparam logic [5:0] F0 = 6'b110_101;
    localparam logic [5:0] F1 = 6'b001_101;
    localparam logic [5:0] J0 = 6'b010_011;
    localparam logic [5:0] J1 = 6'b010_111;

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic [5:0] fdat;
        logic [5:0] jdat;
        logic [5:0] exp_data;
        logic [1:0] exp_act;
        logic       exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic [1:0] sel0;
    logic [5:0] fdat;
    logic [5:0] jdat;
    logic [5:0] dout;
    logic [5:0] dout0;
    logic [1:0] act;
    logic [1:0] act0;
    logic       busy;
    logic       busy0;
    logic       busy0_seen = 1'b0;

    int checks = 0;
    int errors = 0;

    vec_t tbl[17];

    // clock / reset block
    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_data_mux_sync #(
        .WIDTH(W), .CHANNELS(CH), .SETTLE_CYCLES(2)
    ) dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst),
        .ijtag_select       (sel),
        .functional_data_in (fdat),
        .ijtag_data_in      (jdat),
        .data_out           (dout),
        .ijtag_active       (act),
        .switch_busy        (busy)
    );

    firebird7_in_gate1_tessent_data_mux_sync #(
        .WIDTH(W), .CHANNELS(CH), .SETTLE_CYCLES(0)
    ) dut0 (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst),
        .ijtag_select       (sel0),
        .functional_data_in (fdat),
        .ijtag_data_in      (jdat),
        .data_out           (dout0),
        .ijtag_active       (act0),
        .switch_busy        (busy0)
    );

    always @(negedge clk) begin
        if (busy0 === 1'b1) busy0_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_main(input string tag, input logic [5:0] ed, input logic [1:0] ea, input logic eb);
        check({tag, " data"}, 32'(dout), 32'(ed));
        check({tag, " active"}, 32'(act), 32'(ea));
        check({tag, " busy"}, 32'(busy), 32'(eb));
    endtask

    initial begin
        rst  = 1'b1;
        sel  = 2'b00;
        sel0 = 2'b00;
        fdat = F0;
        jdat = J0;

        tbl[0]  = '{1'b1, 2'b00, F0, J0, 6'b000_000, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, F0, J0, 6'b000_000, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, F0, J0, 6'b110_101, 2'b00, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, F0, J0, 6'b110_101, 2'b00, 1'b1};
        tbl[4]  = '{1'b0, 2'b01, F0, J0, 6'b110_101, 2'b00, 1'b1};
        tbl[5]  = '{1'b0, 2'b01, F0, J0, 6'b110_101, 2'b01, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, F0, J0, 6'b110_011, 2'b01, 1'b0};
        tbl[7]  = '{1'b0, 2'b01, F1, J0, 6'b001_011, 2'b01, 1'b0};
        tbl[8]  = '{1'b0, 2'b01, F1, J1, 6'b001_111, 2'b01, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, F1, J1, 6'b001_111, 2'b00, 1'b1};
        tbl[10] = '{1'b0, 2'b00, F1, J1, 6'b001_111, 2'b00, 1'b1};
        tbl[11] = '{1'b0, 2'b00, F1, J1, 6'b001_111, 2'b00, 1'b0};
        tbl[12] = '{1'b0, 2'b00, F1, J1, 6'b001_101, 2'b00, 1'b0};
        tbl[13] = '{1'b0, 2'b11, F1, J1, 6'b001_101, 2'b00, 1'b1};
        tbl[14] = '{1'b0, 2'b11, F1, J1, 6'b001_101, 2'b00, 1'b1};
        tbl[15] = '{1'b0, 2'b11, F1, J1, 6'b001_101, 2'b11, 1'b0};
        tbl[16] = '{1'b0, 2'b11, F1, J1, 6'b010_111, 2'b11, 1'b0};

        // table-driven vectors
        for (int i = 0; i < 17; i++) begin
            rst  = tbl[i].rst;
            sel  = tbl[i].sel;
            fdat = tbl[i].fdat;
            jdat = tbl[i].jdat;
            tick();
            check_main($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_act, tbl[i].exp_busy);
            if (tbl[i].rst) check($sformatf("vec%0d s0 data", i), 32'(dout0), 32'd0);
        end

        // select reverts for one cycle during HOLD: lane0 returns to FUNC
        rst = 1'b1; sel = 2'b00; tick();
        check_main("rv reset", 6'b000_000, 2'b00, 1'b0);
        rst = 1'b0; tick();
        check_main("rv func", 6'b001_101, 2'b00, 1'b0);
        sel = 2'b01; tick();
        check_main("rv hold1", 6'b001_101, 2'b00, 1'b1);
        sel = 2'b00; tick();
        check_main("rv hold2", 6'b001_101, 2'b00, 1'b1);
        tick();
        check_main("rv exit", 6'b001_101, 2'b00, 1'b0);
        fdat = 6'b001_100; tick();
        check_main("rv func2", 6'b001_100, 2'b00, 1'b0);
        fdat = F1;

        // reset in the second HOLD cycle abandons the switch
        sel = 2'b10; tick();
        check_main("rh hold1", 6'b001_101, 2'b00, 1'b1);
        tick();
        check_main("rh hold2", 6'b001_101, 2'b00, 1'b1);
        rst = 1'b1; tick();
        check_main("rh reset", 6'b000_000, 2'b00, 1'b0);
        rst = 1'b0; sel = 2'b00; tick();
        check_main("rh func", 6'b001_101, 2'b00, 1'b0);

        // settle-0 instance: direct switch, one-edge latency
        sel0 = 2'b01; tick();
        check("s0 sw data", 32'(dout0), 32'(6'b001_101));
        check("s0 sw active", 32'(act0), 32'd1);
        tick();
        check("s0 ijtag data", 32'(dout0), 32'(6'b001_111));
        sel0 = 2'b00; tick();
        check("s0 back data", 32'(dout0), 32'(6'b001_111));
        check("s0 back active", 32'(act0), 32'd0);
        tick();
        check("s0 func data", 32'(dout0), 32'(6'b001_101));
        check("s0 busy never", 32'(busy0_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_sync.md
FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_SYNC -- requirements
Module: firebird7_in_gate1_tessent_data_mux_sync

Interface
REQ-001 Parameter WIDTH, default 3, data bits per channel (>=1).
REQ-002 Parameter CHANNELS, default 2, number of independent mux lanes (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 2, hold cycles inserted on every source switch (>=0).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 ijtag_tck  input  1  clock; all state updates on rising edge.
REQ-006 ijtag_reset  input  1  synchronous active-high reset.
REQ-007 ijtag_select  input  CHANNELS  per-lane request: 1 = IJTAG source, 0 = functional source.
REQ-008 functional_data_in  input  CHANNELS*WIDTH  functional data; lane k at bits [k*WIDTH +: WIDTH].
REQ-009 ijtag_data_in  input  CHANNELS*WIDTH  IJTAG data, same packing.
REQ-010 data_out  output  CHANNELS*WIDTH  registered muxed data, same packing.
REQ-011 ijtag_active  output  CHANNELS  per-lane: 1 when lane is in state IJTAG.
REQ-012 switch_busy  output  1  OR of all lanes being in state HOLD.

Function
REQ-013 Each lane SHALL run an independent FSM with states FUNC, HOLD, IJTAG.
REQ-014 FUNC: data_out lane <= functional lane input every cycle; if select=1, go to HOLD (target IJTAG) with counter loaded to SETTLE_CYCLES-1.
REQ-015 IJTAG: data_out lane <= IJTAG lane input every cycle; if select=0, go to HOLD (target FUNC) with counter loaded to SETTLE_CYCLES-1.
REQ-016 HOLD: data_out lane SHALL keep its last registered value; counter decrements each cycle.
REQ-017 HOLD exit when counter=0: next state is IJTAG if select=1, else FUNC, evaluated on that exit cycle (target recorded at entry is ignored; select reverting mid-HOLD returns lane to its origin).
REQ-018 First cycle in the new state SHALL load data_out from the new source (data latency 1 cycle from input to data_out in FUNC/IJTAG).
REQ-019 SETTLE_CYCLES=0: lanes SHALL switch directly FUNC<->IJTAG with no HOLD state, switch_busy constant 0.
REQ-020 Switch latency: select change at edge N produces data from new source on data_out after edge N+SETTLE_CYCLES+1.
REQ-021 Counter width SHALL be max(1,$clog2(SETTLE_CYCLES+1)); counter never wraps (stops at 0).
REQ-022 ijtag_active and switch_busy SHALL be registered-state decodes, valid the same cycle as data_out.
REQ-023 Lanes SHALL not interact; simultaneous select changes on multiple lanes proceed in parallel.

Reset
REQ-024 On ijtag_reset=1 at a clock edge: all lanes -> FUNC, counters 0, data_out all 0, ijtag_active 0, switch_busy 0.
REQ-025 Reset asserted mid-HOLD SHALL abandon the switch; first post-reset cycle loads functional data.
REQ-026 Reset SHALL take priority over every select change in the same cycle.

Structure
REQ-027 Lane state enum (FUNC, HOLD, IJTAG) SHALL live in shared package firebird7_in_gate1_tessent_data_mux_pkg.
REQ-028 One sub-module firebird7_in_gate1_tessent_data_mux_lane (one FSM, counter, WIDTH-bit output register) SHALL be instantiated CHANNELS times via generate.
REQ-029 Top level SHALL contain only unpacking/packing, generate loop and the switch_busy OR reduction.

Verification (WIDTH=3, CHANNELS=2, SETTLE_CYCLES=2)
REQ-030 Reset: hold reset 2 cycles with func=3'b101/3'b110 -> data_out=0, ijtag_active=0; cycle after release data_out lane0=5, lane1=6.
REQ-031 Switch lane0 to IJTAG (ijtag lane0=3'b011): data_out lane0 holds 5 for 2 cycles with switch_busy=1, then 3; ijtag_active[0]=1; lane1 unaffected.
REQ-032 Revert: select lane0 1->0 for one cycle during HOLD -> lane0 returns to FUNC after HOLD, never outputs 3, ijtag_active[0] stays 0.
REQ-033 Both lanes switch same edge -> both complete after 3 cycles; switch_busy high exactly 2 cycles.
REQ-034 Reset asserted in second HOLD cycle -> data_out 0 next cycle, lanes FUNC, switch_busy 0.
REQ-035 SETTLE_CYCLES=0 build: select toggle -> new-source data on data_out after 1 edge, switch_busy never 1.
